diff_commit_sequencer: RTL and testbench

Commit sequencer between the core's write-back stage and the difftest bridge. Buffers retired-instruction records, with their optional store/load and exception side-information, in a small FIFO. Replays them to the bridge at most one per cycle with a monotonically wrapping commit index. Inserts a bubble after every exception record so the CSR state snapshot sampled by the bridge is stable before the next commit.

---
 rtl/diff_commit_sequencer_if.sv | 65 ++++++
 rtl/diff_commit_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_diff_commit_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/diff_commit_sequencer_if.sv
// Commit-record bus between write-back, the commit sequencer and the difftest bridge.
// "slave" is the sequencer's view; "master" is the write-back/bridge environment's view.
interface diff_commit_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_skip;
  logic        in_wen;
  logic [7:0]  in_wdest;
  logic [63:0] in_wdata;
  logic        in_excp;
  logic        in_is_mret;
  logic [31:0] in_cause;
  logic [7:0]  in_st_valid;
  logic [63:0] in_st_paddr;
  logic [63:0] in_st_data;
  logic [7:0]  in_ld_valid;
  logic [63:0] in_ld_paddr;
  logic [63:0] in_ld_data;
  logic        out_stall;

  logic        instrValid;
  logic [7:0]  index;
  logic [63:0] the_pc;
  logic [31:0] instr;
  logic        skip;
  logic        wen;
  logic [7:0]  wdest;
  logic [63:0] wdata;
  logic        excp_valid;
  logic        isMret;
  logic [31:0] cause;
  logic [63:0] exceptionPC;
  logic [31:0] exceptionInst;
  logic [7:0]  storeIndex;
  logic [7:0]  storeValid;
  logic [63:0] storePaddr;
  logic [63:0] storeData;
  logic [7:0]  loadIndex;
  logic [7:0]  loadValid;
  logic [63:0] loadPaddr;
  logic [63:0] loadData;
  logic        busy;

  modport slave (
    input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
           in_excp, in_is_mret, in_cause, in_st_valid, in_st_paddr, in_st_data,
           in_ld_valid, in_ld_paddr, in_ld_data, out_stall,
    output in_ready, instrValid, index, the_pc, instr, skip, wen, wdest, wdata,
           excp_valid, isMret, cause, exceptionPC, exceptionInst,
           storeIndex, storeValid, storePaddr, storeData,
           loadIndex, loadValid, loadPaddr, loadData, busy
  );

  modport master (
    output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
           in_excp, in_is_mret, in_cause, in_st_valid, in_st_paddr, in_st_data,
           in_ld_valid, in_ld_paddr, in_ld_data, out_stall,
    input  in_ready, instrValid, index, the_pc, instr, skip, wen, wdest, wdata,
           excp_valid, isMret, cause, exceptionPC, exceptionInst,
           storeIndex, storeValid, storePaddr, storeData,
           loadIndex, loadValid, loadPaddr, loadData, busy
  );
endinterface

// File: rtl/diff_commit_sequencer.sv
// Buffers retired-instruction records and replays them to the difftest bridge, one per cycle,
// with a bubble after each exception. Store/load forwarding is built only with DIFF_MEM_EVENT_EN.
module diff_commit_sequencer #(
  parameter int DEPTH = 4
) (
  input logic                    clock,
  input logic                    reset,
  diff_commit_sequencer_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        excp;
    logic        is_mret;
    logic [31:0] cause;
`ifdef DIFF_MEM_EVENT_EN
    logic [7:0]  st_valid;
    logic [63:0] st_paddr;
    logic [63:0] st_data;
    logic [7:0]  ld_valid;
    logic [63:0] ld_paddr;
    logic [63:0] ld_data;
`endif
  } rec_t;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  rec_t          mem_q [DEPTH];
  rec_t          wrec;
  rec_t          rrec;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [7:0]    cnt_q;
  logic          push, pop;

  logic          instr_valid_q, excp_valid_q, is_mret_q;
  logic [7:0]    index_q;
  logic [63:0]   pc_q, wdata_q, epc_q;
  logic [31:0]   instr_q, cause_q, einst_q;
  logic          skip_q, wen_q;
  logic [7:0]    wdest_q;

  always_comb begin
    wrec         = '0;
    wrec.pc      = io.in_pc;
    wrec.instr   = io.in_instr;
    wrec.skip    = io.in_skip;
    wrec.wen     = io.in_wen;
    wrec.wdest   = io.in_wdest;
    wrec.wdata   = io.in_wdata;
    wrec.excp    = io.in_excp;
    wrec.is_mret = io.in_is_mret;
    wrec.cause   = io.in_cause;
`ifdef DIFF_MEM_EVENT_EN
    wrec.st_valid = io.in_st_valid;
    wrec.st_paddr = io.in_st_paddr;
    wrec.st_data  = io.in_st_data;
    wrec.ld_valid = io.in_ld_valid;
    wrec.ld_paddr = io.in_ld_paddr;
    wrec.ld_data  = io.in_ld_data;
`endif
  end

  assign io.in_ready = (count_q != CW'(DEPTH));
  assign push        = io.in_valid && io.in_ready;
  assign pop         = (state_q == EMIT) && (count_q != '0) && !io.out_stall;
  assign rrec        = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Record storage carries no reset: only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wrec;
  end

`ifdef DIFF_MEM_EVENT_EN
  logic [7:0]  st_valid_q, st_index_q, ld_valid_q, ld_index_q;
  logic [63:0] st_paddr_q, st_data_q, ld_paddr_q, ld_data_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      instr_valid_q <= 1'b0;
      excp_valid_q  <= 1'b0;
      is_mret_q     <= 1'b0;
      index_q       <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      skip_q        <= 1'b0;
      wen_q         <= 1'b0;
      wdest_q       <= '0;
      wdata_q       <= '0;
      cause_q       <= '0;
      epc_q         <= '0;
      einst_q       <= '0;
`ifdef DIFF_MEM_EVENT_EN
      st_valid_q    <= '0;
      st_index_q    <= '0;
      st_paddr_q    <= '0;
      st_data_q     <= '0;
      ld_valid_q    <= '0;
      ld_index_q    <= '0;
      ld_paddr_q    <= '0;
      ld_data_q     <= '0;
`endif
    end else begin
      count_q       <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      instr_valid_q <= 1'b0;
      excp_valid_q  <= 1'b0;
      is_mret_q     <= 1'b0;
`ifdef DIFF_MEM_EVENT_EN
      st_valid_q    <= '0;
      ld_valid_q    <= '0;
`endif
      case (state_q)
        IDLE:    if (count_q != '0) state_q <= EMIT;
        EMIT: begin
          // An exception pop always takes the bubble, even if the FIFO drains.
          if (pop && rrec.excp)    state_q <= GAP;
          else if (count_d == '0)  state_q <= IDLE;
        end
        GAP:     state_q <= (count_d != '0) ? EMIT : IDLE;
        default: state_q <= IDLE;
      endcase
      if (pop) begin
        instr_valid_q <= !rrec.excp || rrec.is_mret;
        excp_valid_q  <= rrec.excp;
        is_mret_q     <= rrec.excp && rrec.is_mret;
        pc_q          <= rrec.pc;
        instr_q       <= rrec.instr;
        skip_q        <= rrec.skip;
        wen_q         <= rrec.wen;
        wdest_q       <= rrec.wdest;
        wdata_q       <= rrec.wdata;
        if (rrec.excp) begin
          cause_q <= rrec.cause;
          epc_q   <= rrec.pc;
          einst_q <= rrec.instr;
        end
        // The commit index only advances on records that raise instrValid.
        if (!rrec.excp || rrec.is_mret) begin
          index_q <= cnt_q;
          cnt_q   <= cnt_q + 8'd1;
        end
`ifdef DIFF_MEM_EVENT_EN
        st_valid_q <= rrec.st_valid;
        st_index_q <= cnt_q;
        st_paddr_q <= rrec.st_paddr;
        st_data_q  <= rrec.st_data;
        ld_valid_q <= rrec.ld_valid;
        ld_index_q <= cnt_q;
        ld_paddr_q <= rrec.ld_paddr;
        ld_data_q  <= rrec.ld_data;
`endif
      end
    end
  end

  assign io.instrValid    = instr_valid_q;
  assign io.index         = index_q;
  assign io.the_pc        = pc_q;
  assign io.instr         = instr_q;
  assign io.skip          = skip_q;
  assign io.wen           = wen_q;
  assign io.wdest         = wdest_q;
  assign io.wdata         = wdata_q;
  assign io.excp_valid    = excp_valid_q;
  assign io.isMret        = is_mret_q;
  assign io.cause         = cause_q;
  assign io.exceptionPC   = epc_q;
  assign io.exceptionInst = einst_q;
  assign io.busy          = (count_q != '0) || (state_q != IDLE);

`ifdef DIFF_MEM_EVENT_EN
  assign io.storeValid = st_valid_q;
  assign io.storeIndex = st_index_q;
  assign io.storePaddr = st_paddr_q;
  assign io.storeData  = st_data_q;
  assign io.loadValid  = ld_valid_q;
  assign io.loadIndex  = ld_index_q;
  assign io.loadPaddr  = ld_paddr_q;
  assign io.loadData   = ld_data_q;
`else
  logic unused_mem_inputs;
  assign unused_mem_inputs = ^{io.in_st_valid, io.in_st_paddr, io.in_st_data,
                               io.in_ld_valid, io.in_ld_paddr, io.in_ld_data};
  assign io.storeValid = '0;
  assign io.storeIndex = '0;
  assign io.storePaddr = '0;
  assign io.storeData  = '0;
  assign io.loadValid  = '0;
  assign io.loadIndex  = '0;
  assign io.loadPaddr  = '0;
  assign io.loadData   = '0;
`endif
endmodule

// File: tb/tb_diff_commit_sequencer.sv
// Directed bench for diff_commit_sequencer: reset, streaming, stall/backpressure,
// exception bubble, mret, store forwarding, index wrap and mid-stream reset.
module tb_diff_commit_sequencer;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  diff_commit_sequencer_if bus ();

  diff_commit_sequencer #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

`ifdef DIFF_MEM_EVENT_EN
  localparam logic MEM_EN = 1'b1;
`else
  localparam logic MEM_EN = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rec(input logic v, input logic [63:0] pc, input logic excp,
                         input logic mret, input logic [31:0] cause, input logic [7:0] stv);
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_instr    = excp ? (mret ? 32'h30200073 : 32'h00000073) : (pc[31:0] ^ 32'h00000013);
    bus.in_skip     = 1'b0;
    bus.in_wen      = !excp;
    bus.in_wdest    = 8'd5;
    bus.in_wdata    = ~pc;
    bus.in_excp     = excp;
    bus.in_is_mret  = mret;
    bus.in_cause    = cause;
    bus.in_st_valid = stv;
    bus.in_st_paddr = 64'h80001000;
    bus.in_st_data  = 64'h1122334455667788;
    bus.in_ld_valid = stv;
    bus.in_ld_paddr = 64'h80002000;
    bus.in_ld_data  = 64'h99AABBCCDDEEFF00;
  endtask

  task automatic do_reset();
    set_rec(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.out_stall = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_rec(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.out_stall = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    total++; if (bus.instrValid !== 1'b0) begin bad++; $display("FAIL rst_instrValid got=%0h exp=0", bus.instrValid); end
    total++; if (bus.excp_valid !== 1'b0 || bus.isMret !== 1'b0) begin bad++; $display("FAIL rst_excp got=%0h/%0h exp=0/0", bus.excp_valid, bus.isMret); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); end
    total++; if (bus.index !== 8'd0 || bus.the_pc !== 64'd0) begin bad++; $display("FAIL rst_data got=%0h/%0h exp=0/0", bus.index, bus.the_pc); end
    total++; if (bus.storeValid !== 8'd0 || bus.loadValid !== 8'd0) begin bad++; $display("FAIL rst_memvalid got=%0h/%0h exp=0/0", bus.storeValid, bus.loadValid); end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] pc;
    logic        ev;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      set_rec(j < 3, 64'h80000000 + 64'(4 * j), 1'b0, 1'b0, 32'h0, 8'h0);
      tick();
      ev = (j >= 2) && (j <= 4);
      pc = 64'h80000000 + 64'(4 * (j - 2));
      total++; if (bus.instrValid !== ev) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%0h exp=%0h", j, bus.instrValid, ev); end
      if (ev) begin
        total++; if (bus.the_pc !== pc || bus.wdata !== ~pc) begin bad++; $display("FAIL b2b_pc cyc=%0d got=%0h exp=%0h", j, bus.the_pc, pc); end
        total++; if (bus.index !== 8'(j - 2)) begin bad++; $display("FAIL b2b_index cyc=%0d got=%0d exp=%0d", j, bus.index, j - 2); end
      end
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0h exp=0", bus.busy); end
  endtask

  task automatic test_stall();
    int          acc;
    logic        rdy;
    logic [63:0] base;
    base = 64'h80000100;
    acc  = 0;
    do_reset();
    bus.out_stall = 1'b1;
    for (int j = 0; j < 6; j++) begin
      set_rec(1'b1, base + 64'(4 * acc), 1'b0, 1'b0, 32'h0, 8'h0);
      rdy = bus.in_ready;
      tick();
      if (rdy) acc++;
      total++; if (bus.in_ready !== (acc != 4)) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0h exp=%0h", j, bus.in_ready, acc != 4); end
      total++; if (bus.instrValid !== 1'b0) begin bad++; $display("FAIL stall_valid cyc=%0d got=%0h exp=0", j, bus.instrValid); end
    end
    total++; if (acc !== 4) begin bad++; $display("FAIL stall_accepted got=%0d exp=4", acc); end
    bus.out_stall = 1'b0;
    for (int j = 0; j < 7; j++) begin
      set_rec(acc < 5, base + 64'(4 * acc), 1'b0, 1'b0, 32'h0, 8'h0);
      rdy = bus.in_ready;
      tick();
      if (bus.in_valid && rdy) acc++;
      total++; if (bus.instrValid !== (j < 5)) begin bad++; $display("FAIL drain_valid cyc=%0d got=%0h exp=%0h", j, bus.instrValid, j < 5); end
      if (j < 5) begin
        total++; if (bus.the_pc !== base + 64'(4 * j) || bus.index !== 8'(j)) begin bad++; $display("FAIL drain_rec cyc=%0d got=%0h/%0d exp=%0h/%0d", j, bus.the_pc, bus.index, base + 64'(4 * j), j); end
      end
    end
  endtask

  task automatic test_exception();
    do_reset();
    for (int j = 0; j < 6; j++) begin
      if (j == 0)      set_rec(1'b1, 64'h80000100, 1'b1, 1'b0, 32'd2, 8'h0);
      else if (j == 1) set_rec(1'b1, 64'h80000104, 1'b0, 1'b0, 32'd0, 8'h0);
      else             set_rec(1'b0, 64'h0, 1'b0, 1'b0, 32'd0, 8'h0);
      tick();
      total++; if (bus.excp_valid !== (j == 2)) begin bad++; $display("FAIL exc_excp_valid cyc=%0d got=%0h exp=%0h", j, bus.excp_valid, j == 2); end
      total++; if (bus.instrValid !== (j == 4)) begin bad++; $display("FAIL exc_instrValid cyc=%0d got=%0h exp=%0h", j, bus.instrValid, j == 4); end
      if (j == 2) begin
        total++; if (bus.cause !== 32'd2 || bus.exceptionPC !== 64'h80000100 || bus.exceptionInst !== 32'h00000073) begin bad++; $display("FAIL exc_info got=%0h/%0h/%0h exp=2/80000100/73", bus.cause, bus.exceptionPC, bus.exceptionInst); end
        total++; if (bus.isMret !== 1'b0 || bus.index !== 8'd0) begin bad++; $display("FAIL exc_mret_index got=%0h/%0d exp=0/0", bus.isMret, bus.index); end
      end
      if (j == 4) begin
        total++; if (bus.index !== 8'd0 || bus.the_pc !== 64'h80000104) begin bad++; $display("FAIL exc_next got=%0d/%0h exp=0/80000104", bus.index, bus.the_pc); end
      end
    end
  endtask

  task automatic test_mret();
    do_reset();
    for (int j = 0; j < 6; j++) begin
      if (j == 0)      set_rec(1'b1, 64'h80000200, 1'b1, 1'b1, 32'd0, 8'h0);
      else if (j == 1) set_rec(1'b1, 64'h80000204, 1'b0, 1'b0, 32'd0, 8'h0);
      else             set_rec(1'b0, 64'h0, 1'b0, 1'b0, 32'd0, 8'h0);
      tick();
      total++; if (bus.instrValid !== (j == 2 || j == 4)) begin bad++; $display("FAIL mret_instrValid cyc=%0d got=%0h exp=%0h", j, bus.instrValid, j == 2 || j == 4); end
      total++; if (bus.isMret !== (j == 2) || bus.excp_valid !== (j == 2)) begin bad++; $display("FAIL mret_flags cyc=%0d got=%0h/%0h exp=%0h", j, bus.isMret, bus.excp_valid, j == 2); end
      if (j == 2) begin
        total++; if (bus.index !== 8'd0 || bus.the_pc !== 64'h80000200) begin bad++; $display("FAIL mret_rec got=%0d/%0h exp=0/80000200", bus.index, bus.the_pc); end
      end
      if (j == 4) begin
        total++; if (bus.index !== 8'd1) begin bad++; $display("FAIL mret_next_index got=%0d exp=1", bus.index); end
      end
    end
  endtask

  task automatic test_store();
    logic [7:0]  exp_sv;
    logic [7:0]  exp_si;
    logic [63:0] exp_sp;
    logic [63:0] exp_lp;
    exp_sv = MEM_EN ? 8'h0F : 8'h00;
    exp_si = MEM_EN ? 8'd7 : 8'd0;
    exp_sp = MEM_EN ? 64'h80001000 : 64'h0;
    exp_lp = MEM_EN ? 64'h80002000 : 64'h0;
    do_reset();
    for (int j = 0; j < 11; j++) begin
      set_rec(j < 8, 64'h80000300 + 64'(4 * j), 1'b0, 1'b0, 32'd0, (j == 7) ? 8'h0F : 8'h00);
      tick();
      if (j == 8) begin
        total++; if (bus.storeValid !== 8'h00 || bus.instrValid !== 1'b1) begin bad++; $display("FAIL st_prev got=%0h/%0h exp=0/1", bus.storeValid, bus.instrValid); end
      end
      if (j == 9) begin
        total++; if (bus.instrValid !== 1'b1 || bus.index !== 8'd7) begin bad++; $display("FAIL st_commit got=%0h/%0d exp=1/7", bus.instrValid, bus.index); end
        total++; if (bus.storeValid !== exp_sv || bus.storeIndex !== exp_si || bus.storePaddr !== exp_sp) begin bad++; $display("FAIL st_event got=%0h/%0d/%0h exp=%0h/%0d/%0h", bus.storeValid, bus.storeIndex, bus.storePaddr, exp_sv, exp_si, exp_sp); end
        total++; if (bus.loadValid !== (MEM_EN ? 8'h0F : 8'h00) || bus.loadIndex !== exp_si || bus.loadPaddr !== exp_lp) begin bad++; $display("FAIL ld_event got=%0h/%0d/%0h exp=%0h/%0d/%0h", bus.loadValid, bus.loadIndex, bus.loadPaddr, exp_sv, exp_si, exp_lp); end
      end
      if (j == 10) begin
        total++; if (bus.storeValid !== 8'h00 || bus.loadValid !== 8'h00) begin bad++; $display("FAIL st_pulse got=%0h/%0h exp=0/0", bus.storeValid, bus.loadValid); end
      end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int j = 0; j < 262; j++) begin
      set_rec(j < 260, 64'(4 * j), 1'b0, 1'b0, 32'd0, 8'h0);
      tick();
      if (j >= 2) begin
        total++; if (bus.instrValid !== 1'b1 || bus.index !== 8'(j - 2)) begin bad++; $display("FAIL wrap cyc=%0d got=%0h/%0d exp=1/%0d", j, bus.instrValid, bus.index, (j - 2) % 256); end
      end
    end
    bus.out_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_rec(1'b1, 64'hDEAD0000 + 64'(j), 1'b0, 1'b0, 32'd0, 8'h0);
      tick();
    end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_prebusy got=%0h exp=1", bus.busy); end
    do_reset();
    total++; if (bus.instrValid !== 1'b0 || bus.excp_valid !== 1'b0 || bus.storeValid !== 8'h0) begin bad++; $display("FAIL midrst_valids got=%0h/%0h/%0h exp=0/0/0", bus.instrValid, bus.excp_valid, bus.storeValid); end
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%0h/%0h exp=1/0", bus.in_ready, bus.busy); end
    for (int j = 0; j < 4; j++) begin
      set_rec(j == 0, 64'h00000ABC, 1'b0, 1'b0, 32'd0, 8'h0);
      tick();
      total++; if (bus.instrValid !== (j == 2)) begin bad++; $display("FAIL midrst_after cyc=%0d got=%0h exp=%0h", j, bus.instrValid, j == 2); end
      if (j == 2) begin
        total++; if (bus.index !== 8'd0 || bus.the_pc !== 64'h00000ABC) begin bad++; $display("FAIL midrst_rec got=%0d/%0h exp=0/abc", bus.index, bus.the_pc); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.out_stall = 1'b0;
    set_rec(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 8'h0);
    test_reset();
    test_back_to_back();
    test_stall();
    test_exception();
    test_mret();
    test_store();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
